// File: rtl/rnn_pkg.sv
// rtl/rnn_pkg.sv - register map and state encoding for the RNN accelerator sequencer
package rnn_pkg;

    localparam logic [31:0] ADDR_START  = 32'd0;
    localparam logic [31:0] ADDR_INPUT  = 32'd1;
    localparam logic [31:0] ADDR_W0     = 32'd2;
    localparam logic [31:0] ADDR_W1     = 32'd3;
    localparam logic [31:0] ADDR_RBIAS  = 32'd4;
    localparam logic [31:0] ADDR_DENSE  = 32'd5;
    localparam logic [31:0] ADDR_DBIAS  = 32'd6;
    localparam logic [31:0] ADDR_RESULT = 32'd7;

    // Select field of an input-vector write: which element of the pair is loaded
    localparam logic [7:0] SEL_E0 = 8'h00;
    localparam logic [7:0] SEL_E1 = 8'h01;

    typedef enum logic [3:0] {
        IDLE,
        WR_I0,
        WR_I1,
        START,
        WAIT,
        DENSE,
        POLL,
        READ,
        OUT
    } state_t;

endpackage

// File: rtl/rnn_sequencer_if.sv
// rtl/rnn_sequencer_if.sv - sample stream, slave bus and result handshake of the sequencer
interface rnn_sequencer_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;

    logic        m_read;
    logic        m_write;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;

    modport master (
        input  in_valid, in_data, in_last,
        output in_ready,
        output m_read, m_write, m_addr, m_wdata,
        input  m_rdata,
        output res_valid, res_data,
        input  res_ready
    );

    modport slave (
        output in_valid, in_data, in_last,
        input  in_ready,
        input  m_read, m_write, m_addr, m_wdata,
        output m_rdata,
        input  res_valid, res_data,
        output res_ready
    );

endinterface

// File: rtl/rnn_sequencer.sv
// rtl/rnn_sequencer.sv - bus master that steps the RNN accelerator per sample and fetches the dense result
module rnn_sequencer
    import rnn_pkg::*;
#(
    parameter int STEP_WAIT  = 64,
    parameter int POLL_LIMIT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    rnn_sequencer_if.master  bus,
    output logic             busy,
    output logic             timeout
);

    localparam int          PW        = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;
    localparam logic [15:0] WAIT_LOAD = 16'(STEP_WAIT - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);

    state_t        r_state;
    logic [31:0]   r_data;
    logic          r_last;
    logic [15:0]   r_wait_cnt;
    logic [PW-1:0] r_poll_cnt;
    logic          r_in_ready;
    logic          r_m_read;
    logic          r_m_write;
    logic [31:0]   r_m_addr;
    logic [31:0]   r_m_wdata;
    logic          r_res_valid;
    logic [15:0]   r_res_data;
    logic          r_busy;
    logic          r_timeout;

    // Sequencer FSM; every transition also loads the strobes/flags of the state being entered,
    // so a state's bus access appears in the cycle it is first occupied.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_data      <= '0;
            r_last      <= 1'b0;
            r_wait_cnt  <= '0;
            r_poll_cnt  <= '0;
            r_in_ready  <= 1'b0;
            r_m_read    <= 1'b0;
            r_m_write   <= 1'b0;
            r_m_addr    <= '0;
            r_m_wdata   <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_busy      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_m_read  <= 1'b0;
            r_m_write <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_data     <= bus.in_data;
                        r_last     <= bus.in_last;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_m_write  <= 1'b1;
                        r_m_addr   <= ADDR_INPUT;
                        r_m_wdata  <= {8'h00, SEL_E0, bus.in_data[15:0]};
                        r_state    <= WR_I0;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                WR_I0: begin
                    r_m_write <= 1'b1;
                    r_m_addr  <= ADDR_INPUT;
                    r_m_wdata <= {8'h00, SEL_E1, r_data[31:16]};
                    r_state   <= WR_I1;
                end
                WR_I1: begin
                    r_m_write <= 1'b1;
                    r_m_addr  <= ADDR_START;
                    r_state   <= START;
                end
                START: begin
                    r_wait_cnt <= WAIT_LOAD;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    if (r_wait_cnt == '0) begin
                        if (r_last) begin
                            // Dense layer is kicked by a write to the result register
                            r_m_write <= 1'b1;
                            r_m_addr  <= ADDR_RESULT;
                            r_state   <= DENSE;
                        end else begin
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= IDLE;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 16'd1;
                    end
                end
                DENSE: begin
                    r_poll_cnt <= '0;
                    r_m_read   <= 1'b1;
                    r_m_addr   <= ADDR_START;
                    r_state    <= POLL;
                end
                POLL: begin
                    if (bus.m_rdata[0]) begin
                        r_m_read <= 1'b1;
                        r_m_addr <= ADDR_RESULT;
                        r_state  <= READ;
                    end else if (r_poll_cnt == POLL_LAST) begin
                        r_timeout  <= 1'b1;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= IDLE;
                    end else begin
                        r_poll_cnt <= r_poll_cnt + 1'b1;
                        r_m_read   <= 1'b1;
                        r_m_addr   <= ADDR_START;
                    end
                end
                READ: begin
                    r_res_data  <= bus.m_rdata[15:0];
                    r_res_valid <= 1'b1;
                    r_state     <= OUT;
                end
                OUT: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.m_read    = r_m_read;
    assign bus.m_write   = r_m_write;
    assign bus.m_addr    = r_m_addr;
    assign bus.m_wdata   = r_m_wdata;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign busy          = r_busy;
    assign timeout       = r_timeout;

endmodule

// File: tb/tb_rnn_sequencer.sv
// tb/tb_rnn_sequencer.sv - directed self-checking bench for rnn_sequencer with a behavioural slave
module tb_rnn_sequencer;

    localparam int SW = 8;
    localparam int PL = 16;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    logic timeout;
    logic never_done;

    rnn_sequencer_if bus ();

    rnn_sequencer #(.STEP_WAIT(SW), .POLL_LIMIT(PL)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] s_in0, s_in1, s_sum;
    logic [2:0]  s_dcnt;
    logic        s_done;
    int          cyc = 0;
    int          viol_both = 0;
    int          viol_idle = 0;
    int          timeout_cnt = 0;
    int          resv_cnt = 0;
    int          res_hs = 0;
    txn_t        log_q[$];

    // Slave: stores the input pair, accumulates e0+e1 per step, reports done 5 cycles after the dense kick
    always @(posedge clk) begin
        if (!rst_n) begin
            s_in0 <= '0; s_in1 <= '0; s_sum <= '0; s_dcnt <= '0; s_done <= 1'b0;
        end else begin
            if (bus.m_write && bus.m_addr == 32'd1) begin
                if (bus.m_wdata[23:16] == 8'h00) s_in0 <= bus.m_wdata[15:0];
                else                             s_in1 <= bus.m_wdata[15:0];
            end
            if (bus.m_write && bus.m_addr == 32'd0) s_sum <= s_sum + s_in0 + s_in1;
            if (bus.m_write && bus.m_addr == 32'd7) begin
                s_dcnt <= 3'd5; s_done <= 1'b0;
            end else if (s_dcnt != 3'd0) begin
                s_dcnt <= s_dcnt - 3'd1;
                if (s_dcnt == 3'd1) s_done <= 1'b1;
            end
            if (bus.m_read && bus.m_addr == 32'd7) begin
                s_done <= 1'b0; s_sum <= '0;
            end
        end
    end

    // Slave read data is combinational on the strobe
    always_comb begin
        bus.m_rdata = '0;
        if (bus.m_read && bus.m_addr == 32'd0) bus.m_rdata = {31'd0, s_done & ~never_done};
        if (bus.m_read && bus.m_addr == 32'd7) bus.m_rdata = {16'hA5A5, 16'h1000 + s_sum};
    end

    // Bus monitor: transaction log and protocol counters
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.m_read || bus.m_write) log_q.push_back('{bus.m_write, bus.m_addr, bus.m_wdata, cyc});
        if (bus.m_read && bus.m_write) viol_both <= viol_both + 1;
        if (!bus.m_read && !bus.m_write && (bus.m_addr != 0 || bus.m_wdata != 0)) viol_idle <= viol_idle + 1;
        if (timeout) timeout_cnt <= timeout_cnt + 1;
        if (bus.res_valid) resv_cnt <= resv_cnt + 1;
        if (bus.res_valid && bus.res_ready) res_hs <= res_hs + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int count_log(input logic wr, input logic [31:0] addr);
        int n = 0;
        foreach (log_q[i]) if (log_q[i].wr == wr && log_q[i].addr == addr) n++;
        return n;
    endfunction

    task automatic send_sample(input logic [31:0] d, input logic l);
        int n = 0;
        bus.in_data  = d;
        bus.in_last  = l;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("accept_in_time", 32'(n < 300), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_ready(output int lo);
        lo = 0;
        while (bus.in_ready !== 1'b1 && lo < 500) begin
            lo++;
            @(negedge clk);
        end
    endtask

    task automatic wait_result(input logic [15:0] exp, input string tag);
        int n = 0;
        while (bus.res_valid !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
        check({tag, "_data"}, 32'(bus.res_data), 32'(exp));
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check({tag, "_valid_one_cycle"}, 32'(bus.res_valid), 32'd0);
    endtask

    initial begin
        int lo;
        int n;
        int bad;
        int rdy_seen;
        int snap_sz, snap_to, snap_rv, snap_hs;
        logic        e_wr[11];
        logic [31:0] e_addr[11];
        logic [31:0] e_data[11];

        rst_n = 1'b0;
        never_done = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_last = 1'b0;
        bus.res_ready = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_m_read", 32'(bus.m_read), 32'd0);
        check("rst_m_write", 32'(bus.m_write), 32'd0);
        check("rst_m_addr", bus.m_addr, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_data", 32'(bus.res_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(bus.in_ready), 32'd1);

        // Single sample, last=1: exact bus sequence and result
        log_q.delete();
        send_sample(32'h0002_0001, 1'b1);
        wait_result(16'h1003, "t1");
        for (int i = 0; i < 11; i++) begin
            e_wr[i] = 1'b0; e_addr[i] = 32'd0; e_data[i] = 32'd0;
        end
        e_wr[0] = 1'b1; e_addr[0] = 32'd1; e_data[0] = 32'h0000_0001;
        e_wr[1] = 1'b1; e_addr[1] = 32'd1; e_data[1] = 32'h0001_0002;
        e_wr[2] = 1'b1; e_addr[2] = 32'd0;
        e_wr[3] = 1'b1; e_addr[3] = 32'd7;
        e_addr[10] = 32'd7;
        check("t1_txn_count", 32'(log_q.size()), 32'd11);
        if (log_q.size() == 11) begin
            for (int i = 0; i < 11; i++) begin
                check($sformatf("t1_txn%0d_wr", i), 32'(log_q[i].wr), 32'(e_wr[i]));
                check($sformatf("t1_txn%0d_addr", i), log_q[i].addr, e_addr[i]);
                check($sformatf("t1_txn%0d_data", i), log_q[i].data, e_data[i]);
            end
            check("t1_start_to_dense_gap", 32'(log_q[3].cyc - log_q[2].cyc), 32'(SW + 1));
        end

        // Three-sample sequence
        log_q.delete();
        snap_hs = res_hs;
        send_sample(32'h0003_0004, 1'b0);
        wait_ready(lo);
        check("t2_gap1", 32'(lo), 32'(SW + 3));
        send_sample(32'h0010_0020, 1'b0);
        wait_ready(lo);
        check("t2_gap2", 32'(lo), 32'(SW + 3));
        send_sample(32'h0100_0005, 1'b1);
        wait_result(16'h113C, "t2");
        check("t2_input_start_writes", 32'(count_log(1'b1, 32'd1) + count_log(1'b1, 32'd0)), 32'd9);
        check("t2_dense_writes", 32'(count_log(1'b1, 32'd7)), 32'd1);
        check("t2_result_reads", 32'(count_log(1'b0, 32'd7)), 32'd1);
        check("t2_results", 32'(res_hs - snap_hs), 32'd1);

        // Result held against backpressure while the next sample waits
        send_sample(32'h0040_0008, 1'b1);
        n = 0;
        while (bus.res_valid !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("t3_valid", 32'(bus.res_valid), 32'd1);
        bus.in_data = 32'h0001_0001;
        bus.in_last = 1'b1;
        bus.in_valid = 1'b1;
        snap_sz = log_q.size();
        bad = 0;
        rdy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.res_valid !== 1'b1 || bus.res_data !== 16'h1048) bad++;
            if (bus.in_ready === 1'b1) rdy_seen++;
        end
        check("t3_hold_stable", 32'(bad), 32'd0);
        check("t3_data", 32'(bus.res_data), 32'h1048);
        check("t3_not_accepted", 32'(rdy_seen), 32'd0);
        check("t3_no_bus_activity", 32'(log_q.size()), 32'(snap_sz));
        check("t3_busy", 32'(busy), 32'd1);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        send_sample(32'h0001_0001, 1'b1);
        wait_result(16'h1002, "t3b");

        // Slave never reports done: timeout abort
        never_done = 1'b1;
        log_q.delete();
        snap_to = timeout_cnt;
        snap_rv = resv_cnt;
        send_sample(32'h0005_0005, 1'b1);
        n = 0;
        while (timeout !== 1'b1 && n < SW + PL + 50) begin
            @(negedge clk);
            n++;
        end
        check("t4_timeout_seen", 32'(timeout), 32'd1);
        check("t4_idle_busy", 32'(busy), 32'd0);
        check("t4_idle_ready", 32'(bus.in_ready), 32'd1);
        repeat (5) @(negedge clk);
        check("t4_timeout_pulses", 32'(timeout_cnt - snap_to), 32'd1);
        check("t4_no_result", 32'(resv_cnt - snap_rv), 32'd0);
        check("t4_polls", 32'(count_log(1'b0, 32'd0)), 32'(PL));
        check("t4_no_result_read", 32'(count_log(1'b0, 32'd7)), 32'd0);
        never_done = 1'b0;

        // Reset during WAIT of the second sample, then a fresh sequence
        send_sample(32'h0001_0001, 1'b0);
        wait_ready(lo);
        send_sample(32'h0002_0002, 1'b0);
        repeat (5) @(negedge clk);
        check("t5_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_m_read", 32'(bus.m_read), 32'd0);
        check("t5_m_write", 32'(bus.m_write), 32'd0);
        check("t5_m_addr", bus.m_addr, 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_ready_after_rst", 32'(bus.in_ready), 32'd1);
        send_sample(32'h0003_0004, 1'b1);
        wait_result(16'h1007, "t5");

        repeat (2) @(negedge clk);
        check("both_strobes", 32'(viol_both), 32'd0);
        check("idle_bus_nonzero", 32'(viol_idle), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
